snake_pixel_reader: RTL and testbench



---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_pixel_addr.sv | 26 ++
 rtl/snake_pixel_reader.sv | 126 ++++++++++++
 tb/tb_snake_pixel_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: frame geometry, colour
// encoding, movement directions and the pixel reader state machine.
package snake_pkg;

    localparam int FRAME_W = 160;
    localparam int FRAME_H = 120;
    localparam int ADDR_W  = 15;
    localparam int CLR_W   = 3;

    localparam logic [CLR_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } reader_state_t;

endpackage

// File: rtl/snake_pixel_addr.sv
// Wrap-aware frame address: (x+dx, y+dy) taken modulo the frame size, then
// flattened to y*WIDTH + x. Shared by the shadow-RAM reader and writer.
module snake_pixel_addr #(
    parameter int WIDTH  = snake_pkg::FRAME_W,
    parameter int HEIGHT = snake_pkg::FRAME_H,
    parameter int ADDR_W = snake_pkg::ADDR_W
) (
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic              dx,
    input  logic              dy,
    output logic [ADDR_W-1:0] addr
);

    logic [8:0] x_pix;
    logic [7:0] y_pix;

    // Origins are in range, so a +1 step only ever wraps from the last column/row.
    always_comb begin
        x_pix = (dx && (x == 9'(WIDTH - 1)))  ? 9'd0 : x + 9'(dx);
        y_pix = (dy && (y == 8'(HEIGHT - 1))) ? 8'd0 : y + 8'(dy);
    end

    assign addr = ADDR_W'(y_pix) * ADDR_W'(WIDTH) + ADDR_W'(x_pix);

endmodule

// File: rtl/snake_pixel_reader.sv
// Reads back the 2x2 block at a candidate head position from the shadow frame
// RAM and reports whether any pixel is non-background (collision or food).
module snake_pixel_reader #(
    parameter int WIDTH  = snake_pkg::FRAME_W,
    parameter int HEIGHT = snake_pkg::FRAME_H,
    parameter int ADDR_W = snake_pkg::ADDR_W,
    parameter int CLR_W  = snake_pkg::CLR_W,
    parameter logic [CLR_W-1:0] BG_COLOUR = snake_pkg::BG_COLOUR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [8:0]        req_x,
    input  logic [7:0]        req_y,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              hit,
    output logic [CLR_W-1:0]  hit_colour,
    output logic              oob,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CLR_W-1:0]  rd_data
);

    import snake_pkg::*;

    reader_state_t     state;
    reader_state_t     next_state;
    logic [8:0]        org_x;
    logic [7:0]        org_y;
    logic [1:0]        cnt;
    logic              cap_valid;
    logic              accept;
    logic              req_oob;
    logic [ADDR_W-1:0] pix_addr;

    assign accept  = (state == IDLE) && req_valid;
    assign req_oob = (req_x >= 9'(WIDTH)) || (req_y >= 8'(HEIGHT));

    snake_pixel_addr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x    (org_x),
        .y    (org_y),
        .dx   (cnt[0]),
        .dy   (cnt[1]),
        .addr (pix_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = req_oob ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                rd_en   = 1'b1;
                rd_addr = pix_addr;
                if (cnt == 2'd3) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // cap_valid trails rd_en by one cycle to match the RAM read latency; the
    // first non-background pixel sets hit, which then locks hit_colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            org_x      <= '0;
            org_y      <= '0;
            cnt        <= '0;
            cap_valid  <= 1'b0;
            hit        <= 1'b0;
            hit_colour <= BG_COLOUR;
            oob        <= 1'b0;
        end else begin
            cap_valid <= (state == ISSUE);
            if (state == ISSUE) begin
                cnt <= cnt + 2'd1;
            end
            if (accept) begin
                org_x      <= req_x;
                org_y      <= req_y;
                cnt        <= '0;
                hit        <= req_oob;
                hit_colour <= BG_COLOUR;
                oob        <= req_oob;
            end else if (cap_valid && !hit && (rd_data != BG_COLOUR)) begin
                hit        <= 1'b1;
                hit_colour <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_snake_pixel_reader.sv
// Scoreboard bench for snake_pixel_reader against a behavioural shadow RAM.
module tb_snake_pixel_reader;

    import snake_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [8:0]  req_x;
    logic [7:0]  req_y;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        hit;
    logic [2:0]  hit_colour;
    logic        oob;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;

    typedef struct {
        logic       hit;
        logic [2:0] colour;
        logic       oob;
        int         latency;
    } resp_t;

    int    exp_addr_q[$];
    resp_t exp_resp_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic [2:0] ram [0:FRAME_W*FRAME_H-1];

    snake_pixel_reader dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .hit        (hit),
        .hit_colour (hit_colour),
        .oob        (oob),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Every read strobe must match the next expected address in order.
    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_addr_q.size() == 0) checkOutput("rd_en_extra", 32'(rd_en), 0);
            else checkOutput("rd_addr", 32'(rd_addr), exp_addr_q.pop_front());
        end
    end

    function automatic int modelAddr(int x, int y, int dx, int dy);
        return ((y + dy) % FRAME_H) * FRAME_W + ((x + dx) % FRAME_W);
    endfunction

    task automatic applyStimulus(input int x, input int y);
        resp_t r;
        int    w = 0;
        r.hit = 1'b0; r.colour = BG_COLOUR; r.oob = 1'b0; r.latency = 6;
        if (x >= FRAME_W || y >= FRAME_H) begin
            r.hit = 1'b1; r.oob = 1'b1; r.latency = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int a = modelAddr(x, y, i % 2, i / 2);
                exp_addr_q.push_back(a);
                if (!r.hit && ram[a] != BG_COLOUR) begin
                    r.hit = 1'b1; r.colour = ram[a];
                end
            end
        end
        exp_resp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b1; req_x = 9'(x); req_y = 8'(y);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        checkOutput("req_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitResponse();
        resp_t r;
        int    cycles = 0;
        do begin @(negedge clk); cycles++; end while (!resp_valid && cycles < 20);
        r = exp_resp_q.pop_front();
        checkOutput("resp_latency", 32'(cycles), 32'(r.latency));
        checkOutput("hit", 32'(hit), 32'(r.hit));
        checkOutput("hit_colour", 32'(hit_colour), 32'(r.colour));
        checkOutput("oob", 32'(oob), 32'(r.oob));
    endtask

    task automatic acceptResponse();
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("resp_drop", 32'(resp_valid), 0);
        checkOutput("idle_ready", 32'(req_ready), 1);
        checkOutput("addr_q_empty", 32'(exp_addr_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < FRAME_W*FRAME_H; i++) ram[i] = BG_COLOUR;
        rd_data = BG_COLOUR; req_valid = 1'b0; req_x = '0; req_y = '0; resp_ready = 1'b0;
        reset = 1'b1;
        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_hit", 32'(hit), 0);
        checkOutput("rst_hit_colour", 32'(hit_colour), 32'(BG_COLOUR));
        checkOutput("rst_oob", 32'(oob), 0);
        checkOutput("rst_rd_en", 32'(rd_en), 0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] all background, origin (64,60)");
        applyStimulus(64, 60); waitResponse(); acceptResponse();

        $display("[TB] single lit pixel at (65,61)");
        ram[61*FRAME_W + 65] = 3'b111;
        applyStimulus(64, 60); waitResponse(); acceptResponse();

        $display("[TB] first mismatch wins");
        ram[60*FRAME_W + 64] = 3'b010;
        applyStimulus(64, 60); waitResponse(); acceptResponse();

        $display("[TB] corner wrap at (159,119)");
        ram[61*FRAME_W + 65] = BG_COLOUR;
        ram[60*FRAME_W + 64] = BG_COLOUR;
        ram[0] = 3'b100;
        applyStimulus(159, 119); waitResponse(); acceptResponse();
        ram[0] = BG_COLOUR;

        $display("[TB] out-of-frame origin with held response");
        applyStimulus(160, 10); waitResponse();
        req_valid = 1'b1; req_x = 9'd10; req_y = 8'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_resp_valid", 32'(resp_valid), 1);
            checkOutput("hold_req_ready", 32'(req_ready), 0);
            checkOutput("hold_hit", 32'(hit), 1);
            checkOutput("hold_oob", 32'(oob), 1);
        end
        req_valid = 1'b0;
        acceptResponse();

        $display("[TB] reset during issue");
        applyStimulus(64, 60);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_rd_en", 32'(rd_en), 0);
        checkOutput("mid_rst_rd_addr", 32'(rd_addr), 0);
        checkOutput("mid_rst_req_ready", 32'(req_ready), 1);
        checkOutput("mid_rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("mid_rst_hit", 32'(hit), 0);
        checkOutput("mid_rst_oob", 32'(oob), 0);
        exp_addr_q.delete();
        exp_resp_q.delete();
        @(negedge clk) reset = 1'b0;

        $display("[TB] normal request after reset, origin (10,10)");
        applyStimulus(10, 10); waitResponse(); acceptResponse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
